dunit_host_ctrl: RTL and testbench
==================================

# dunit_host_ctrl

Debug-unit host controller: the driving end of the pipeline's `dunit` debug interface. It sits between the UART byte receiver/transmitter and the `pipeline` top. It decodes single-byte host commands, then does one of the following:
- loads program words into instruction memory;
- runs or single-steps the pipeline;
- streams back the register file and a window of data memory.

It replaces the stimulus that benches currently hand-drive on the `i_dunit_*` ports.

## Interface
- `NB_REG`, 32: data word width
- `NB_WIDHT`, 9: debug address width (byte address, 128 instruction words)
- `NB_BYTE`, 8: UART byte width
- `N_MEM`, 16: data-memory words returned per dump
- `RUN_MAX`, 1024: run-mode cycle limit
- `i_clk` in 1: clock
- `i_reset` in 1: asynchronous, active-low reset
- `i_rx_data` in `NB_BYTE`: received byte
- `i_rx_valid` in 1: one-cycle strobe, `i_rx_data` valid
- `i_tx_busy` in 1: transmitter busy
- `o_tx_data` out `NB_BYTE`: byte to send
- `o_tx_start` out 1: one-cycle send strobe
- `i_halt` in 1: pipeline has retired HALT
- `i_dunit_reg` in `NB_REG`: register file read data at `o_dunit_addr[4:0]`
- `i_dunit_mem_data` in `NB_REG`: data memory read data at `o_dunit_addr`
- `o_dunit_clk_en` out 1: pipeline advance enable
- `o_dunit_reset_pc` out 1: hold PC at 0
- `o_dunit_w_mem` out 1: instruction memory write strobe
- `o_dunit_addr` out `NB_WIDHT`: debug address
- `o_dunit_data_if` out `NB_REG`: instruction write data

## Operation
- **Command bytes:**
  - `0x4C` 'L': load
  - `0x52` 'R': run
  - `0x53` 'S': step
  - `0x44` 'D': dump
  - Any other byte: send `0xEE` and return to IDLE.
- **States:** IDLE, LD_CNT, LD_BYTE, LD_WR, RUN, STEP, DMP_ADDR, DMP_CAP, DMP_TX, ACK.
- **Load ('L'):**
  - Next byte is N, the word count.
  - N=0 or N>128: send `0xEE`, return to IDLE.
  - Otherwise receive 4·N bytes, MSB first. Each completed word k is written at address 4·k.
  - `o_dunit_reset_pc`=1 from LD_CNT entry to ACK exit.
  - After the last write, send `0xAA`.
- **Run ('R'):**
  - `o_dunit_clk_en`=1 until `i_halt` is sampled high, or until `RUN_MAX` enabled cycles elapse.
  - Then dump.
  - Final ack: `0xAA` on halt, `0xEF` on timeout.
- **Step ('S'):** `o_dunit_clk_en`=1 for exactly one cycle, then dump, then `0xAA`.
- **Dump ('D'):** dump only, then `0xAA`.
- **Dump sequence:**
  - Registers 0..31: `o_dunit_addr`=k.
  - Then memory words 0..`N_MEM`−1: `o_dunit_addr`=4·k.
  - Each word is captured and sent as 4 bytes, MSB first.
  - Total bytes = 128 + 4·`N_MEM` + 1 ack (193 by default).
- `o_dunit_clk_en`=0 in every state other than RUN and STEP. The pipeline is frozen during load and dump.
- `i_rx_valid` is ignored in RUN, STEP, DMP_*, and ACK. Those bytes are dropped.

## Timing
- **Reset:** all outputs 0, state IDLE, byte and word counters 0. Async assert takes effect immediately. Mid-operation reset discards any partial word and any in-progress dump.
- **Load write:**
  - The 4th byte is strobed in cycle t.
  - In t+1: `o_dunit_w_mem`=1 for exactly that one cycle, with `o_dunit_addr`=4·k and `o_dunit_data_if`=the assembled word.
  - Addr and data stay stable through that cycle.
- **Command decode:** command byte strobed in cycle t → state change visible in t+1.
  - Run: `o_dunit_clk_en` rises in t+1.
  - Step: `o_dunit_clk_en` high only in t+1.
- **Run stop:** `i_halt` sampled high at an edge → `o_dunit_clk_en` low in the next cycle. The enabled-cycle counter saturates at `RUN_MAX`. If halt and timeout fall in the same cycle, halt wins (ack `0xAA`).
- **Dump read latency:** 1 cycle. DMP_ADDR drives the address; DMP_CAP registers `i_dunit_reg`/`i_dunit_mem_data` on the following edge.
- **Transmit handshake:**
  - `o_tx_start` is pulsed for one cycle only when `i_tx_busy`=0, with `o_tx_data` valid in that cycle.
  - The next byte is not offered until `i_tx_busy` has been seen high and then low again.
  - No lost or duplicated bytes under any busy pattern.
- **Back-to-back commands:** a command byte arriving in the cycle ACK's `0xAA` is accepted by the transmitter is dropped. Commands are accepted only in IDLE.

## Test plan
1. **Load two words:** 'L', N=2, bytes `20 01 00 01 20 02 00 02`. Expect `o_dunit_w_mem` pulses at addr 0 with `0x20010001` and at addr 4 with `0x20020002`, `o_dunit_reset_pc`=1 throughout, tx `0xAA`.
2. **Bad count:** 'L', N=0 → tx `0xEE`, no `o_dunit_w_mem` pulse. Unknown command `0x7A` → tx `0xEE`.
3. **Step:** 'S' → `o_dunit_clk_en` high exactly 1 cycle, then 193 bytes. Register bytes match a stub returning k for register k (`00 00 00 01` for register 1). Last byte `0xAA`.
4. **Run to halt:** 'R', stub raises `i_halt` after 37 enabled cycles → `o_dunit_clk_en` high exactly 37 cycles (low the cycle after halt), dump, ack `0xAA`. Same test with halt never asserted → exactly 1024 cycles, ack `0xEF`.
5. **Tx back-pressure:** 'D' with `i_tx_busy` held 10–50 random cycles per byte → exactly 193 start pulses, byte stream identical to the zero-delay case.
6. **Reset mid-load:** drop `i_reset` after byte 3 of word 0 → all outputs 0 immediately. After release, a fresh 'L' N=1 writes the correct word at addr 0.

Source files
------------

// File: rtl/dunit_host_ctrl.sv
// Host-side driver for the pipeline debug unit: decodes UART command bytes,
// loads instruction memory, runs/steps the pipeline and streams back state.
module dunit_host_ctrl #(
  parameter int unsigned NB_REG   = 32,
  parameter int unsigned NB_WIDHT = 9,
  parameter int unsigned NB_BYTE  = 8,
  parameter int unsigned N_MEM    = 16,
  parameter int unsigned RUN_MAX  = 1024
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [NB_BYTE-1:0]  i_rx_data,
  input  logic                i_rx_valid,
  input  logic                i_tx_busy,
  output logic [NB_BYTE-1:0]  o_tx_data,
  output logic                o_tx_start,
  input  logic                i_halt,
  input  logic [NB_REG-1:0]   i_dunit_reg,
  input  logic [NB_REG-1:0]   i_dunit_mem_data,
  output logic                o_dunit_clk_en,
  output logic                o_dunit_reset_pc,
  output logic                o_dunit_w_mem,
  output logic [NB_WIDHT-1:0] o_dunit_addr,
  output logic [NB_REG-1:0]   o_dunit_data_if
);

  localparam int unsigned NB_RUN = $clog2(RUN_MAX + 1);
  localparam logic [NB_BYTE-1:0] CMD_LOAD  = NB_BYTE'(8'h4C);
  localparam logic [NB_BYTE-1:0] CMD_RUN   = NB_BYTE'(8'h52);
  localparam logic [NB_BYTE-1:0] CMD_STEP  = NB_BYTE'(8'h53);
  localparam logic [NB_BYTE-1:0] CMD_DUMP  = NB_BYTE'(8'h44);
  localparam logic [NB_BYTE-1:0] ACK_OK    = NB_BYTE'(8'hAA);
  localparam logic [NB_BYTE-1:0] ACK_ERR   = NB_BYTE'(8'hEE);
  localparam logic [NB_BYTE-1:0] ACK_TMO   = NB_BYTE'(8'hEF);
  localparam logic [NB_BYTE-1:0] N_REGS    = NB_BYTE'(32);
  localparam logic [NB_BYTE-1:0] MAX_WORDS = NB_BYTE'(128);
  localparam logic [NB_BYTE-1:0] LAST_WORD = NB_BYTE'(32 + N_MEM - 1);
  localparam logic [NB_RUN-1:0]  RUN_LAST  = NB_RUN'(RUN_MAX - 1);

  typedef enum logic [3:0] {
    IDLE, LD_CNT, LD_BYTE, LD_WR, RUN, STEP, DMP_ADDR, DMP_CAP, DMP_TX, ACK
  } state_t;

  typedef enum logic [1:0] {TX_READY, TX_WAIT_HI, TX_WAIT_LO} tx_ph_t;

  state_t               state_q;
  tx_ph_t               tx_ph_q;
  logic [NB_BYTE-1:0]   n_q;
  logic [NB_BYTE-1:0]   word_cnt_q;
  logic [1:0]           byte_cnt_q;
  logic [NB_REG-1:0]    word_q;
  logic [NB_RUN-1:0]    run_cnt_q;
  logic [NB_BYTE-1:0]   ack_q;
  logic [NB_BYTE-1:0]   tx_data_q;
  logic                 tx_start_q;
  logic                 clk_en_q;
  logic                 reset_pc_q;
  logic                 w_mem_q;
  logic [NB_WIDHT-1:0]  addr_q;
  logic [NB_REG-1:0]    data_if_q;
  logic                 tx_ok;

  // Dump order: registers at their index, then data memory at byte addresses.
  function automatic logic [NB_WIDHT-1:0] dump_addr(input logic [NB_BYTE-1:0] idx);
    logic [NB_WIDHT-1:0] a;
    if (idx < N_REGS) a = NB_WIDHT'(idx);
    else              a = NB_WIDHT'({idx - N_REGS, 2'b00});
    return a;
  endfunction

  assign tx_ok = (tx_ph_q == TX_READY) && !i_tx_busy;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      tx_ph_q    <= TX_READY;
      n_q        <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      run_cnt_q  <= '0;
      ack_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      clk_en_q   <= 1'b0;
      reset_pc_q <= 1'b0;
      w_mem_q    <= 1'b0;
      addr_q     <= '0;
      data_if_q  <= '0;
    end else begin
      w_mem_q    <= 1'b0;
      tx_start_q <= 1'b0;

      // A byte is complete only once busy has been seen high and then low.
      case (tx_ph_q)
        TX_WAIT_HI: if (i_tx_busy)  tx_ph_q <= TX_WAIT_LO;
        TX_WAIT_LO: if (!i_tx_busy) tx_ph_q <= TX_READY;
        default: ;
      endcase

      case (state_q)
        IDLE: if (i_rx_valid) begin
          case (i_rx_data)
            CMD_LOAD: begin
              state_q    <= LD_CNT;
              reset_pc_q <= 1'b1;
            end
            CMD_RUN: begin
              state_q   <= RUN;
              clk_en_q  <= 1'b1;
              run_cnt_q <= '0;
              ack_q     <= ACK_OK;
            end
            CMD_STEP: begin
              state_q  <= STEP;
              clk_en_q <= 1'b1;
              ack_q    <= ACK_OK;
            end
            CMD_DUMP: begin
              state_q    <= DMP_ADDR;
              ack_q      <= ACK_OK;
              word_cnt_q <= '0;
              addr_q     <= dump_addr('0);
            end
            default: begin
              state_q <= ACK;
              ack_q   <= ACK_ERR;
            end
          endcase
        end
        LD_CNT: if (i_rx_valid) begin
          if (i_rx_data == '0 || i_rx_data > MAX_WORDS) begin
            state_q <= ACK;
            ack_q   <= ACK_ERR;
          end else begin
            state_q    <= LD_BYTE;
            n_q        <= i_rx_data;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
          end
        end
        LD_BYTE: if (i_rx_valid) begin
          word_q     <= {word_q[NB_REG-NB_BYTE-1:0], i_rx_data};
          byte_cnt_q <= byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_q   <= LD_WR;
            w_mem_q   <= 1'b1;
            addr_q    <= NB_WIDHT'({word_cnt_q, 2'b00});
            data_if_q <= {word_q[NB_REG-NB_BYTE-1:0], i_rx_data};
          end
        end
        LD_WR: begin
          word_cnt_q <= word_cnt_q + NB_BYTE'(1);
          if (word_cnt_q == n_q - NB_BYTE'(1)) begin
            state_q <= ACK;
            ack_q   <= ACK_OK;
          end else begin
            state_q <= LD_BYTE;
          end
        end
        RUN: begin
          // Halt is tested first so it wins a tie with the timeout.
          if (i_halt || run_cnt_q == RUN_LAST) begin
            clk_en_q   <= 1'b0;
            ack_q      <= i_halt ? ACK_OK : ACK_TMO;
            state_q    <= DMP_ADDR;
            word_cnt_q <= '0;
            addr_q     <= dump_addr('0);
          end else begin
            run_cnt_q <= run_cnt_q + NB_RUN'(1);
          end
        end
        STEP: begin
          clk_en_q   <= 1'b0;
          state_q    <= DMP_ADDR;
          word_cnt_q <= '0;
          addr_q     <= dump_addr('0);
        end
        DMP_ADDR: state_q <= DMP_CAP;
        DMP_CAP: begin
          word_q     <= (word_cnt_q < N_REGS) ? i_dunit_reg : i_dunit_mem_data;
          byte_cnt_q <= '0;
          state_q    <= DMP_TX;
        end
        DMP_TX: if (tx_ok) begin
          tx_start_q <= 1'b1;
          tx_data_q  <= word_q[NB_REG-1 -: NB_BYTE];
          tx_ph_q    <= TX_WAIT_HI;
          word_q     <= word_q << NB_BYTE;
          byte_cnt_q <= byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (word_cnt_q == LAST_WORD) begin
              state_q <= ACK;
            end else begin
              state_q    <= DMP_ADDR;
              word_cnt_q <= word_cnt_q + NB_BYTE'(1);
              addr_q     <= dump_addr(word_cnt_q + NB_BYTE'(1));
            end
          end
        end
        ACK: if (tx_ok) begin
          tx_start_q <= 1'b1;
          tx_data_q  <= ack_q;
          tx_ph_q    <= TX_WAIT_HI;
          reset_pc_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_tx_data        = tx_data_q;
  assign o_tx_start       = tx_start_q;
  assign o_dunit_clk_en   = clk_en_q;
  assign o_dunit_reset_pc = reset_pc_q;
  assign o_dunit_w_mem    = w_mem_q;
  assign o_dunit_addr     = addr_q;
  assign o_dunit_data_if  = data_if_q;

endmodule

// File: tb/tb_dunit_host_ctrl.sv
// Bench for dunit_host_ctrl: UART/pipeline stubs plus a byte/write scoreboard.
module tb_dunit_host_ctrl;

  localparam int unsigned N_MEM   = 16;
  localparam int unsigned RUN_MAX = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        busy = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        halt;
  logic [31:0] reg_rd;
  logic [31:0] mem_rd;
  logic        clk_en;
  logic        reset_pc;
  logic        w_mem;
  logic [8:0]  addr;
  logic [31:0] data_if;

  dunit_host_ctrl #(
    .NB_REG(32), .NB_WIDHT(9), .NB_BYTE(8), .N_MEM(N_MEM), .RUN_MAX(RUN_MAX)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .i_tx_busy(busy), .o_tx_data(tx_data), .o_tx_start(tx_start), .i_halt(halt),
    .i_dunit_reg(reg_rd), .i_dunit_mem_data(mem_rd), .o_dunit_clk_en(clk_en),
    .o_dunit_reset_pc(reset_pc), .o_dunit_w_mem(w_mem), .o_dunit_addr(addr),
    .o_dunit_data_if(data_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got %0h, nothing expected", name, act);
  endtask

  // Pipeline stub: register k reads as k, memory from a table, halt after N enabled cycles.
  logic [31:0] mem_words [N_MEM];
  int pipe_cnt = 0, halt_base = 0, halt_after = 1;
  bit halt_on = 1'b0;
  assign reg_rd = {27'd0, addr[4:0]};
  assign mem_rd = mem_words[addr[5:2]];
  assign halt   = halt_on && ((pipe_cnt - halt_base) >= (halt_after - 1));
  always @(posedge clk) if (clk_en) pipe_cnt <= pipe_cnt + 1;

  // Transmitter stub: busy for 1 cycle, or 10..50 cycles under back-pressure.
  int busy_left = 0;
  bit bp_mode = 1'b0;
  always @(posedge clk) begin
    if (tx_start) begin
      busy      <= 1'b1;
      busy_left <= bp_mode ? int'($urandom_range(10, 50)) : 1;
    end else if (busy_left > 1) begin
      busy_left <= busy_left - 1;
    end else begin
      busy      <= 1'b0;
      busy_left <= 0;
    end
  end

  // Scoreboard queues and the single per-cycle compare process.
  logic [7:0]  exp_tx[$];
  logic [7:0]  got_tx[$];
  int          exp_wr_addr[$];
  logic [31:0] exp_wr_data[$];
  int en_cycles = 0;
  int starts = 0;
  bit en_allowed = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_start) begin
        starts++;
        got_tx.push_back(tx_data);
        check("tx_start_while_busy", {31'd0, busy}, 32'd0);
        if (exp_tx.size() == 0) fail_msg("tx_extra_byte", {24'd0, tx_data});
        else check("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
      end
      if (w_mem) begin
        if (exp_wr_addr.size() == 0) begin
          fail_msg("imem_extra_write", data_if);
        end else begin
          check("imem_wr_addr", {23'd0, addr}, exp_wr_addr.pop_front());
          check("imem_wr_data", data_if, exp_wr_data.pop_front());
          check("reset_pc_during_write", {31'd0, reset_pc}, 32'd1);
        end
      end
      if (clk_en) begin
        en_cycles++;
        if (!en_allowed) fail_msg("clk_en_outside_run", {31'd0, clk_en});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tick($urandom_range(2, 4));
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_tx.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_tx.size() != 0) fail_msg({name, "_timeout_bytes_left"}, exp_tx.size());
    tick(60);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) exp_tx.push_back(w[8*i +: 8]);
  endtask

  task automatic expect_dump(input logic [7:0] ack);
    for (int k = 0; k < 32; k++) push_word(32'(k));
    for (int m = 0; m < int'(N_MEM); m++) push_word(mem_words[m]);
    exp_tx.push_back(ack);
  endtask

  task automatic do_load(input logic [31:0] words[$]);
    int n;
    logic [31:0] w;
    n = words.size();
    for (int k = 0; k < n; k++) begin
      exp_wr_addr.push_back(4 * k);
      exp_wr_data.push_back(words[k]);
    end
    exp_tx.push_back(8'hAA);
    send_byte(8'h4C);
    check("reset_pc_after_L", {31'd0, reset_pc}, 32'd1);
    send_byte(8'(n));
    for (int k = 0; k < n; k++) begin
      w = words[k];
      for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
    end
    wait_drain("load", 300);
    check("load_writes_left", exp_wr_addr.size(), 32'd0);
    check("reset_pc_after_ack", {31'd0, reset_pc}, 32'd0);
  endtask

  task automatic do_bad(input logic [7:0] cmd, input bit with_cnt, input logic [7:0] cnt);
    exp_tx.push_back(8'hEE);
    send_byte(cmd);
    if (with_cnt) send_byte(cnt);
    wait_drain("bad_cmd", 300);
    check("reset_pc_after_err", {31'd0, reset_pc}, 32'd0);
  endtask

  // Command followed by a dump; a stray byte sent mid-dump must be dropped.
  task automatic do_dump_cmd(input logic [7:0] cmd, input logic [7:0] ack,
                             input int exp_en, input int window);
    int en0;
    got_tx.delete();
    expect_dump(ack);
    en0 = en_cycles;
    en_allowed = (cmd != 8'h44);
    send_byte(cmd);
    tick(window);
    en_allowed = 1'b0;
    send_byte(8'h44);
    check("clk_en_cycles", en_cycles - en0, exp_en);
    wait_drain("dump", 20000);
    check("dump_len", got_tx.size(), 32'd193);
  endtask

  logic [31:0] wq[$];
  logic [7:0]  ref_stream[$];
  int diffs, s0;
  logic [31:0] w0;

  initial begin
    for (int m = 0; m < int'(N_MEM); m++) mem_words[m] = $urandom();

    tick(3);
    #2;
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_clk_en", {31'd0, clk_en}, 32'd0);
    check("rst_reset_pc", {31'd0, reset_pc}, 32'd0);
    check("rst_w_mem", {31'd0, w_mem}, 32'd0);
    check("rst_addr", {23'd0, addr}, 32'd0);
    check("rst_data_if", data_if, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(3);

    // Two fixed words: literal expectations.
    wq.delete();
    wq.push_back(32'h20010001);
    wq.push_back(32'h20020002);
    do_load(wq);

    for (int r = 0; r < 3; r++) begin
      wq.delete();
      for (int k = 0; k < int'($urandom_range(1, 6)); k++) wq.push_back($urandom());
      do_load(wq);
    end

    wq.delete();
    for (int k = 0; k < 128; k++) wq.push_back($urandom());
    do_load(wq);

    do_bad(8'h4C, 1'b1, 8'h00);
    do_bad(8'h4C, 1'b1, 8'd129);
    do_bad(8'h4C, 1'b1, 8'($urandom_range(130, 255)));
    do_bad(8'h7A, 1'b0, 8'h00);
    do_bad(8'h00, 1'b0, 8'h00);

    // Step: exactly one enabled cycle; pin the model with literal bytes.
    do_dump_cmd(8'h53, 8'hAA, 1, 3);
    check("step_reg1_b0", {24'd0, got_tx[4]}, 32'h00);
    check("step_reg1_b1", {24'd0, got_tx[5]}, 32'h00);
    check("step_reg1_b2", {24'd0, got_tx[6]}, 32'h00);
    check("step_reg1_b3", {24'd0, got_tx[7]}, 32'h01);
    check("step_reg31_b3", {24'd0, got_tx[127]}, 32'h1F);
    check("step_last_ack", {24'd0, got_tx[192]}, 32'hAA);

    halt_after = 37;
    halt_base  = pipe_cnt;
    halt_on    = 1'b1;
    do_dump_cmd(8'h52, 8'hAA, 37, 45);
    halt_on = 1'b0;

    halt_after = $urandom_range(1, 90);
    halt_base  = pipe_cnt;
    halt_on    = 1'b1;
    do_dump_cmd(8'h52, 8'hAA, halt_after, halt_after + 8);
    halt_on = 1'b0;

    do_dump_cmd(8'h52, 8'hEF, int'(RUN_MAX), int'(RUN_MAX) + 10);
    check("timeout_last_ack", {24'd0, got_tx[192]}, 32'hEF);

    // Back-pressure: same byte stream as the fast-transmitter dump.
    do_dump_cmd(8'h44, 8'hAA, 0, 0);
    ref_stream = got_tx;
    bp_mode = 1'b1;
    s0 = starts;
    do_dump_cmd(8'h44, 8'hAA, 0, 0);
    bp_mode = 1'b0;
    check("bp_start_pulses", starts - s0, 32'd193);
    diffs = 0;
    for (int i = 0; i < 193; i++) if (got_tx[i] !== ref_stream[i]) diffs++;
    check("bp_stream_diffs", diffs, 32'd0);

    // Reset after byte 3 of word 0, then a clean single-word load.
    send_byte(8'h4C);
    send_byte(8'h01);
    send_byte(8'hDE);
    send_byte(8'hAD);
    send_byte(8'hBE);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_reset_pc", {31'd0, reset_pc}, 32'd0);
    check("midrst_clk_en", {31'd0, clk_en}, 32'd0);
    check("midrst_w_mem", {31'd0, w_mem}, 32'd0);
    check("midrst_tx_start", {31'd0, tx_start}, 32'd0);
    check("midrst_tx_data", {24'd0, tx_data}, 32'd0);
    check("midrst_addr", {23'd0, addr}, 32'd0);
    check("midrst_data_if", data_if, 32'd0);
    @(negedge clk);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    w0 = $urandom();
    wq.delete();
    wq.push_back(w0);
    do_load(wq);

    check("final_tx_left", exp_tx.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
